pipe_exe_muldiv: RTL and testbench
==================================

Name: pipe_exe_muldiv

Overview:
- Iterative multiply/divide unit in the execute stage.
- Consumes the decode/execute pipeline register outputs (operand pair, hi/lo function code, hi/lo enables) and produces the 64-bit HI/LO result.
- Stalls everything upstream while it computes.
- Result is written to HI/LO by the write-back path on the single-cycle done pulse.

Parameters:
- DATA_W, 32, operand/result width; iteration count equals DATA_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  valid hi/lo op present in execute; from (D_hi_ena | D_lo_ena)
- func  in  4  op code: 1=MULT, 2=MULTU, 3=DIV, 4=DIVU; any other value = no op
- op_a  in  DATA_W  rs value (multiplicand / dividend)
- op_b  in  DATA_W  rt value (multiplier / divisor)
- flush  in  1  branch-mispredict flush of execute stage
- busy  out  1  stall request to PC/FD/DE registers (combinational)
- done  out  1  one-cycle pulse; hi_out/lo_out valid
- hi_out  out  DATA_W  product high word / remainder
- lo_out  out  DATA_W  product low word / quotient

Behaviour:
- States: IDLE, CALC, DONE. Iteration counter cnt has width clog2(DATA_W).
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, cnt=0.
  - hi_out=0, lo_out=0, done=0.
  - Internal accumulators cleared.
  - busy=0 while start=0.
- Accept condition: go = start & ~flush & func in {1,2,3,4}.
- busy = (state==IDLE & go) | (state==CALC).
  - busy is 0 in DONE, so the DE register advances on the DONE edge.
- IDLE:
  - On go, latch op_a, op_b and func; latch operand signs and magnitudes (abs for MULT/DIV, raw for MULTU/DIVU).
  - Set cnt=0 and go to CALC.
  - Otherwise remain in IDLE.
- CALC:
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle on the magnitudes.
  - cnt increments each cycle; on cnt==DATA_W-1, go to DONE.
  - Inputs are ignored while in CALC, because the latched copy is used.
- DONE:
  - hi_out/lo_out are registered with the sign-corrected result on entry.
  - done = ~flush for exactly one cycle; then return to IDLE unconditionally.
  - start still high in DONE (same instruction) is never re-accepted.
- Latency for a start accepted in cycle T:
  - busy high during T..T+DATA_W.
  - done high in T+DATA_W+1.
  - Total 34 cycles for DATA_W=32.
- Sign correction:
  - MULT: negate the 64-bit product if sign_a^sign_b.
  - DIV: negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
  - Arithmetic wraps modulo 2^DATA_W.
- Divide by zero (DIV or DIVU, op_b==0):
  - lo_out = all ones, hi_out = raw op_a.
  - No exception; latency unchanged.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo_out=0x80000000, hi_out=0 by natural wrap.
- flush behaviour:
  - flush in CALC: abort and go to IDLE next edge; hi_out/lo_out hold their previous values; no done.
  - flush in DONE: done is suppressed, but hi_out/lo_out are already updated; these registers are not architectural.
  - flush in IDLE together with start: not accepted; busy=0.
- Only on the done pulse may HI/LO be written. hi_out/lo_out hold their values until the next DONE.

Test Plan:
- MULT op_a=0xFFFFFFFE, op_b=3 -> busy high for 33 cycles; done in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU op_a=0xFFFFFFFE, op_b=3 -> hi=0x00000002, lo=0xFFFFFFFA. Back-to-back DIVU presented in the cycle after done is accepted with no gap.
- DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU op_a=7, op_b=0 -> lo=0xFFFFFFFF, hi=0x00000007, done after 34 cycles.
- Prior result hi=1, lo=2; start MULT and assert flush at cnt=10 -> busy low the next cycle, no done, hi/lo remain 1/2. func=0 with start=1 -> busy never rises.
- rst pulsed at cnt=20 mid-DIV -> immediately IDLE, outputs 0, busy=0. A new MULTU 5*6 afterwards -> hi=0, lo=30.

Source files
------------

// File: rtl/pipe_exe_muldiv_if.sv
// rtl/pipe_exe_muldiv_if.sv - execute-stage mul/div operand and result bundle
interface pipe_exe_muldiv_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [3:0]        func;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              flush;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;

    modport master (
        output start, func, op_a, op_b, flush,
        input  busy, done, hi_out, lo_out
    );

    modport slave (
        input  start, func, op_a, op_b, flush,
        output busy, done, hi_out, lo_out
    );
endinterface

// File: rtl/pipe_exe_muldiv.sv
// rtl/pipe_exe_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit producing HI/LO
module pipe_exe_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_exe_muldiv_if.slave   bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [3:0] F_MULT  = 4'd1;
    localparam logic [3:0] F_MULTU = 4'd2;
    localparam logic [3:0] F_DIV   = 4'd3;
    localparam logic [3:0] F_DIVU  = 4'd4;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W-1:0] raw_a;
    logic              is_div;
    logic              sign_a;
    logic              sign_b;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    logic valid_func;
    logic go;
    logic op_signed;

    assign valid_func = (bus.func >= F_MULT) && (bus.func <= F_DIVU);
    assign go         = bus.start & ~bus.flush & valid_func;
    assign op_signed  = (bus.func == F_MULT) || (bus.func == F_DIV);

    assign bus.busy   = ((state == IDLE) & go) | (state == CALC);
    assign bus.done   = (state == DONE) & ~bus.flush;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;

    // One iteration: multiply keeps {acc,q} as a right-shifting product,
    // divide keeps acc as partial remainder and shifts quotient bits into q.
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     shifted;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   acc_nx;
    logic [DATA_W-1:0]   q_nx;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   res_hi;
    logic [DATA_W-1:0]   res_lo;

    always_comb begin
        sum     = {1'b0, acc} + (q[0] ? {1'b0, mag_b} : {(DATA_W+1){1'b0}});
        shifted = {acc, q[DATA_W-1]};
        diff    = shifted - {1'b0, mag_b};
        acc_nx  = sum[DATA_W:1];
        q_nx    = {sum[0], q[DATA_W-1:1]};
        if (is_div) begin
            if (!diff[DATA_W]) begin
                acc_nx = diff[DATA_W-1:0];
                q_nx   = {q[DATA_W-2:0], 1'b1};
            end else begin
                acc_nx = shifted[DATA_W-1:0];
                q_nx   = {q[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod   = {acc_nx, q_nx};
        res_hi = prod[2*DATA_W-1:DATA_W];
        res_lo = prod[DATA_W-1:0];
        if (!is_div) begin
            if (sign_a ^ sign_b) begin
                prod   = -prod;
                res_hi = prod[2*DATA_W-1:DATA_W];
                res_lo = prod[DATA_W-1:0];
            end
        end else if (mag_b == '0) begin
            res_hi = raw_a;
            res_lo = '1;
        end else begin
            res_lo = (sign_a ^ sign_b) ? -q_nx : q_nx;
            res_hi = sign_a ? -acc_nx : acc_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            mag_b  <= '0;
            raw_a  <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state  <= CALC;
                        cnt    <= '0;
                        acc    <= '0;
                        q      <= (op_signed && bus.op_a[DATA_W-1]) ? -bus.op_a : bus.op_a;
                        mag_b  <= (op_signed && bus.op_b[DATA_W-1]) ? -bus.op_b : bus.op_b;
                        raw_a  <= bus.op_a;
                        is_div <= (bus.func == F_DIV) || (bus.func == F_DIVU);
                        sign_a <= op_signed & bus.op_a[DATA_W-1];
                        sign_b <= op_signed & bus.op_b[DATA_W-1];
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_nx;
                        q   <= q_nx;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            state <= DONE;
                            hi_q  <= res_hi;
                            lo_q  <= res_lo;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_exe_muldiv.sv
// tb/tb_pipe_exe_muldiv.sv - randomized self-checking bench for pipe_exe_muldiv
module tb_pipe_exe_muldiv;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_exe_muldiv_if #(.DATA_W(DW)) bus ();

    pipe_exe_muldiv #(.DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Architectural HI/LO result as {hi, lo}, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_model(input logic [3:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [31:0] qq, rr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (f)
            4'd1: return 64'(sa * sb);
            4'd2: return ua * ub;
            4'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                qq = 32'(sa / sb);
                rr = 32'(sa % sb);
                return {rr, qq};
            end
            4'd4: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                qq = 32'(ua / ub);
                rr = 32'(ua % ub);
                return {rr, qq};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Holds start for the whole op (as the stalled DE register would) and
    // checks busy span, done timing, and the result against the model.
    task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit flush_done);
        logic [63:0] exp_r;
        int busy_cycles, done_cnt;
        logic done_last;
        exp_r = ref_model(f, a, b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.func  = f;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.flush = 1'b0;
        #1;
        chk($sformatf("%s busy_at_accept", tag), 64'(bus.busy), 64'd1);
        busy_cycles = 1;
        done_cnt    = 0;
        done_last   = 1'b0;
        for (int k = 1; k <= DW + 1; k++) begin
            @(negedge clk);
            if (k == DW + 1 && flush_done) bus.flush = 1'b1;
            #1;
            if (bus.busy) busy_cycles++;
            if (bus.done) done_cnt++;
            if (k == DW + 1) begin
                done_last = bus.done;
                last_hi   = bus.hi_out;
                last_lo   = bus.lo_out;
            end
        end
        bus.flush = 1'b0;
        chk($sformatf("%s busy_cycles", tag), 64'(busy_cycles), 64'(DW + 1));
        chk($sformatf("%s done_count", tag), 64'(done_cnt), flush_done ? 64'd0 : 64'd1);
        chk($sformatf("%s done_at_34", tag), 64'(done_last), flush_done ? 64'd0 : 64'd1);
        chk($sformatf("%s hi f=%0d a=%h b=%h", tag, f, a, b), 64'(last_hi), 64'(exp_r[63:32]));
        chk($sformatf("%s lo f=%0d a=%h b=%h", tag, f, a, b), 64'(last_lo), 64'(exp_r[31:0]));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        bit seen_busy, seen_done;
        bus.start = 1'b0;
        bus.func  = 4'd0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.flush = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset hi", 64'(bus.hi_out), 64'd0);
        chk("reset lo", 64'(bus.lo_out), 64'd0);
        rst = 1'b0;

        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult hi const", 64'(last_hi), 64'hFFFF_FFFF);
        chk("mult lo const", 64'(last_lo), 64'hFFFF_FFFA);
        bus.start = 1'b0;

        run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("multu hi const", 64'(last_hi), 64'h2);
        chk("multu lo const", 64'(last_lo), 64'hFFFF_FFFA);
        run_op("divu_b2b", 4'd4, 32'd100, 32'd7, 1'b0);
        chk("divu_b2b lo const", 64'(last_lo), 64'd14);
        chk("divu_b2b hi const", 64'(last_hi), 64'd2);
        bus.start = 1'b0;

        run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_neg lo const", 64'(last_lo), 64'hFFFF_FFFD);
        chk("div_neg hi const", 64'(last_hi), 64'hFFFF_FFFF);
        bus.start = 1'b0;
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf lo const", 64'(last_lo), 64'h8000_0000);
        chk("div_ovf hi const", 64'(last_hi), 64'h0);
        bus.start = 1'b0;
        run_op("divu_zero", 4'd4, 32'd7, 32'd0, 1'b0);
        chk("divu_zero lo const", 64'(last_lo), 64'hFFFF_FFFF);
        chk("divu_zero hi const", 64'(last_hi), 64'h7);
        bus.start = 1'b0;

        // Establish hi=1, lo=2, then flush a MULT at cnt=10.
        run_op("prior", 4'd2, 32'h8000_0001, 32'd2, 1'b0);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.func  = 4'd1;
        bus.op_a  = 32'd12345;
        bus.op_b  = 32'hFFFF_0001;
        #1;
        seen_done = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            #1;
            if (bus.done) seen_done = 1'b1;
        end
        chk("flush busy_before", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        #1;
        chk("flush busy_after", 64'(bus.busy), 64'd0);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        seen_busy = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (bus.done) seen_done = 1'b1;
            if (bus.busy) seen_busy = 1'b1;
        end
        chk("flush no_done", 64'(seen_done), 64'd0);
        chk("flush no_busy", 64'(seen_busy), 64'd0);
        chk("flush hi_hold", 64'(bus.hi_out), 64'd1);
        chk("flush lo_hold", 64'(bus.lo_out), 64'd2);

        // Invalid function codes never stall.
        @(negedge clk);
        bus.start = 1'b1;
        bus.func  = 4'd0;
        seen_busy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) bus.func = 4'd5;
            #1;
            if (bus.busy) seen_busy = 1'b1;
            @(negedge clk);
        end
        chk("func_invalid no_busy", 64'(seen_busy), 64'd0);
        bus.start = 1'b0;

        // Asynchronous reset in the middle of a DIV at cnt=20.
        @(negedge clk);
        bus.start = 1'b1;
        bus.func  = 4'd3;
        bus.op_a  = 32'hDEAD_BEEF;
        bus.op_b  = 32'd77;
        for (int k = 1; k <= 21; k++) @(negedge clk);
        #1;
        chk("rst_mid busy_before", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid busy", 64'(bus.busy), 64'd0);
        chk("rst_mid done", 64'(bus.done), 64'd0);
        chk("rst_mid hi", 64'(bus.hi_out), 64'd0);
        chk("rst_mid lo", 64'(bus.lo_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("multu_after_rst", 4'd2, 32'd5, 32'd6, 1'b0);
        chk("multu_after_rst lo const", 64'(last_lo), 64'd30);
        bus.start = 1'b0;

        // Flush during DONE suppresses done but the result is still registered.
        run_op("flush_done", 4'd1, 32'hFFFF_FF00, 32'd1000, 1'b1);
        bus.start = 1'b0;

        for (int i = 0; i < 24; i++) begin
            logic [3:0] f;
            f = 4'($urandom_range(1, 4));
            run_op($sformatf("rand%0d", i), f, pick(), pick(), 1'b0);
            if ($urandom_range(0, 1) == 1) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
